// File: rtl/uart_fifo.sv
//============================================================================
// Module      : uart_fifo
// Description : First-word-fall-through FIFO for the UART data path.
//               The head word is presented combinationally on readData.
//               A simultaneous write and read is accepted while full.
//               While empty, only the write of such a pair is accepted.
//               Optional status (level, sticky overflow/underflow,
//               clear_flags) is built when UART_FIFO_STATUS_EN is defined.
//               Without that macro, those outputs are tied to 0.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module uart_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      writeData,
  input  logic                  we,
  output logic [WIDTH-1:0]      readData,
  input  logic                  re,
  output logic                  notEmpty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_flags
);

  localparam int                  c_DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);
  localparam logic [DEPTH_LOG2:0] c_CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

  // Storage is deliberately left out of reset; only bookkeeping is reset.
  logic [WIDTH-1:0]      r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_DEPTH_CNT);
  // A read while full frees the slot this write lands in.
  assign w_rd_acc = re && !w_empty;
  assign w_wr_acc = we && (!w_full || re);

  assign readData = r_mem[r_rd_ptr];
  assign notEmpty = !w_empty;
  assign full     = w_full;

  // Store accepted words at the write pointer.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= writeData;
    end
  end

  // Pointers wrap naturally; the count tracks accepted writes minus reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (!w_wr_acc && w_rd_acc) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

`ifdef UART_FIFO_STATUS_EN
  logic r_overflow;
  logic r_underflow;
  logic w_set_ov;
  logic w_set_un;

  // A write is dropped only when full and unaccompanied by a read.
  assign w_set_ov = we && w_full && !re;
  assign w_set_un = re && w_empty;

  // Sticky error flags; a same-cycle set event outranks clear_flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_set_ov || (r_overflow && !clear_flags);
      r_underflow <= w_set_un || (r_underflow && !clear_flags);
    end
  end

  assign level     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_clear;

  assign w_unused_clear = clear_flags;
  assign level          = '0;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo.sv
//============================================================================
// Module      : tb_uart_fifo
// Description : Self-checking bench for uart_fifo.
//               A queue-based reference model is compared against the DUT
//               on every falling edge. Directed literal checks pin the
//               model to hand-computed values.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_uart_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] writeData;
  logic       we;
  logic [7:0] readData;
  logic       re;
  logic       notEmpty;
  logic       full;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;
  logic       clear_flags;

  int n_pass  = 0;
  int n_total = 0;

  uart_fifo #(.WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .writeData  (writeData),
    .we         (we),
    .readData   (readData),
    .re         (re),
    .notEmpty   (notEmpty),
    .full       (full),
    .level      (level),
    .overflow   (overflow),
    .underflow  (underflow),
    .clear_flags(clear_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status outputs exist only when the status option is built in.
  function automatic int st(input int v);
`ifdef UART_FIFO_STATUS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: a queue of words plus sticky flags.
  logic [7:0] q[$];
  bit         m_ov;
  bit         m_un;

  always @(posedge clk or negedge reset) begin
    bit m_full, m_empty, rd_ok, wr_ok, set_ov, set_un;
    if (!reset) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      m_full  = (q.size() == 16);
      m_empty = (q.size() == 0);
      rd_ok   = re && !m_empty;
      wr_ok   = we && (!m_full || re);
      set_ov  = we && m_full && !re;
      set_un  = re && m_empty;
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(writeData);
      m_ov = set_ov || (m_ov && !clear_flags);
      m_un = set_un || (m_un && !clear_flags);
    end
  end

  // Compare DUT against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    chk("m_notEmpty",  {31'd0, notEmpty},  {31'd0, q.size() != 0});
    chk("m_full",      {31'd0, full},      {31'd0, q.size() == 16});
    chk("m_level",     {27'd0, level},     st(q.size()));
    chk("m_overflow",  {31'd0, overflow},  st(int'(m_ov)));
    chk("m_underflow", {31'd0, underflow}, st(int'(m_un)));
    if (q.size() != 0) chk("m_readData", {24'd0, readData}, {24'd0, q[0]});
  end

  // Present one set of inputs for exactly one rising edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
    we = w; writeData = d; re = r; clear_flags = c;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; clear_flags = 1'b0; writeData = 8'h00;
  endtask

  initial begin
    int guard;
    reset = 1'b0; we = 1'b0; re = 1'b0; clear_flags = 1'b0; writeData = 8'h00;
    #1;
    chk("rst_notEmpty", {31'd0, notEmpty}, 32'd0);
    chk("rst_full",     {31'd0, full},     32'd0);
    chk("rst_level",    {27'd0, level},    32'd0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single word falls through.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("one_notEmpty", {31'd0, notEmpty}, 32'd1);
    chk("one_readData", {24'd0, readData}, 32'hA5);
    chk("one_level",    {27'd0, level},    st(1));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_notEmpty", {31'd0, notEmpty}, 32'd0);
    chk("pop_level",    {27'd0, level},    32'd0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full",  {31'd0, full},  32'd1);
    chk("fill_level", {27'd0, level}, st(16));
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_flag",  {31'd0, overflow}, st(1));
    chk("ovf_level", {27'd0, level},    st(16));
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", {24'd0, readData}, i);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", {31'd0, notEmpty}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clear", {31'd0, overflow}, 32'd0);

    // Underflow set, clear, and set-beats-clear.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_flag",  {31'd0, underflow}, st(1));
    chk("unf_level", {27'd0, level},     32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("unf_clear", {31'd0, underflow}, 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("unf_prio",  {31'd0, underflow}, st(1));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // Write+read while empty: only the write lands.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("wr_empty_level", {27'd0, level},    st(1));
    chk("wr_empty_data",  {24'd0, readData}, 32'h77);
    chk("wr_empty_unf",   {31'd0, underflow}, st(1));
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Write+read while full: both accepted, 8'h55 comes out 16th.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("wrrd_full_level", {27'd0, level},    st(16));
    chk("wrrd_full_ovf",   {31'd0, overflow}, 32'd0);
    chk("wrrd_full_full",  {31'd0, full},     32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("wrrd_order", {24'd0, readData}, (i < 15) ? (32'h11 + i) : 32'h55);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("wrrd_empty", {31'd0, notEmpty}, 32'd0);

    // 40 interleaved operations across pointer wraps; model checks each cycle.
    for (int k = 0; k < 40; k++) step(1'b1, 8'(8'h80 + k), (k % 3) != 0, 1'b0);
    chk("ilv_level", {27'd0, level}, st(14));
    guard = 0;
    while (notEmpty && guard < 40) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      guard++;
    end
    chk("ilv_drained", {31'd0, notEmpty}, 32'd0);
    chk("ilv_drain_count", guard, 32'd14);

    // Reset mid-operation with words queued.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_notEmpty",  {31'd0, notEmpty},  32'd0);
    chk("arst_full",      {31'd0, full},      32'd0);
    chk("arst_level",     {27'd0, level},     32'd0);
    chk("arst_overflow",  {31'd0, overflow},  32'd0);
    chk("arst_underflow", {31'd0, underflow}, 32'd0);
    we = 1'b1; writeData = 8'hEE; re = 1'b1;
    @(posedge clk); #3;
    we = 1'b0; re = 1'b0; writeData = 8'h00;
    reset = 1'b1;
    #1;
    chk("rst_ignore_we", {31'd0, notEmpty}, 32'd0);
    @(posedge clk); #1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_rst_data",  {24'd0, readData}, 32'h3C);
    chk("post_rst_level", {27'd0, level},    st(1));
    chk("post_rst_ne",    {31'd0, notEmpty}, 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
